// File: rtl/piso_serializer.sv
// -----------------------------------------------------------------------------
// piso_serializer
//
// Parallel-in / serial-out serializer with a valid/ready load handshake and a
// per-bit consume enable (ser_en) on the serial side. A word accepted in one
// cycle shows its first bit on dout in the next cycle. A new word can be taken
// in the same cycle the last bit of the current word is consumed, so
// back-to-back words stream with no idle bit between them.
//
// Parameters
//   DATA_W     parallel word width (2..32)
//   MSB_FIRST  1: bit DATA_W-1 leaves first, 0: bit 0 leaves first
//
// Ports
//   clk         clock, all state changes on the rising edge
//   rst         synchronous reset, active low
//   in_valid    in_data holds a word offered for loading
//   in_data     parallel word
//   in_ready    word offered this cycle is accepted (combinational on ser_en)
//   ser_en      downstream consumes the current serial bit; 0 = stall
//   dout        serial data bit
//   dout_valid  dout carries a word bit
//   dout_first  dout is the first bit of its word
//   dout_last   dout is the last bit of its word
// -----------------------------------------------------------------------------
module piso_serializer #(
  parameter int DATA_W    = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  input  logic              ser_en,
  output logic              dout,
  output logic              dout_valid,
  output logic              dout_first,
  output logic              dout_last
);

  localparam int              CNT_W    = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t              state_reg, state_next;
  logic [DATA_W-1:0]   shreg_reg, shreg_next;
  logic [CNT_W-1:0]    cnt_reg, cnt_next;

  logic [DATA_W-1:0]   shreg_shifted;
  logic                at_last;
  logic                accept;

  // ---------------------------------------------------------------------------
  // Shift network: every bit moves one place toward the output end and the
  // vacated position at the far end fills with zero.
  // ---------------------------------------------------------------------------
  generate
    for (genvar gi = 0; gi < DATA_W; gi++) begin : g_shift
      if (MSB_FIRST) begin : g_msb
        if (gi == 0) begin : g_fill
          assign shreg_shifted[gi] = 1'b0;
        end else begin : g_move
          assign shreg_shifted[gi] = shreg_reg[gi-1];
        end
      end else begin : g_lsb
        if (gi == DATA_W - 1) begin : g_fill
          assign shreg_shifted[gi] = 1'b0;
        end else begin : g_move
          assign shreg_shifted[gi] = shreg_reg[gi+1];
        end
      end
    end
  endgenerate

  assign at_last = (cnt_reg == CNT_LAST);

  // A word may be taken while idle, or while the last bit of the current word
  // is being consumed; the latter is what removes the bubble between words.
  assign in_ready = (state_reg == IDLE) ||
                    ((state_reg == SHIFT) && at_last && ser_en);
  assign accept   = in_valid && in_ready;

  // ---------------------------------------------------------------------------
  // Next-state and output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    shreg_next = shreg_reg;
    cnt_next   = cnt_reg;
    dout       = 1'b0;
    dout_valid = 1'b0;
    dout_first = 1'b0;
    dout_last  = 1'b0;

    case (state_reg)
      IDLE: begin
        if (accept) begin
          shreg_next = in_data;
          cnt_next   = '0;
          state_next = SHIFT;
        end
      end

      SHIFT: begin
        // Outputs depend only on registered state, so they hold steady
        // across a stall without any extra capture logic.
        dout       = MSB_FIRST ? shreg_reg[DATA_W-1] : shreg_reg[0];
        dout_valid = 1'b1;
        dout_first = (cnt_reg == '0);
        dout_last  = at_last;

        if (ser_en) begin
          if (!at_last) begin
            shreg_next = shreg_shifted;
            cnt_next   = cnt_reg + CNT_W'(1);
          end else if (accept) begin
            shreg_next = in_data;
            cnt_next   = '0;
          end else begin
            cnt_next   = '0;
            state_next = IDLE;
          end
        end
      end

      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg <= IDLE;
      shreg_reg <= '0;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      shreg_reg <= shreg_next;
      cnt_reg   <= cnt_next;
    end
  end

endmodule

// File: tb/tb_piso_serializer.sv
// -----------------------------------------------------------------------------
// tb_piso_serializer
//
// Directed bench for piso_serializer. Three instances share clk and rst:
//   dut    DATA_W=4, MSB first  (main sequences)
//   dut_l  DATA_W=4, LSB first  (same stimulus as dut, checked on one word)
//   dut_2  DATA_W=2, MSB first  (own handshake signals, two-bit word sequence)
// Each step drives one cycle's inputs just after a rising edge, then checks
// that cycle's outputs before the next edge.
// -----------------------------------------------------------------------------
module tb_piso_serializer;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [3:0] in_data;
  logic       ser_en;
  logic       in_ready, dout, dout_valid, dout_first, dout_last;
  logic       in_ready_l, dout_l, dout_valid_l, dout_first_l, dout_last_l;

  logic       in_valid2;
  logic [1:0] in_data2;
  logic       ser_en2;
  logic       in_ready2, dout2, dout_valid2, dout_first2, dout_last2;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  piso_serializer #(.DATA_W(4), .MSB_FIRST(1'b1)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .ser_en(ser_en),
    .dout(dout), .dout_valid(dout_valid),
    .dout_first(dout_first), .dout_last(dout_last)
  );

  piso_serializer #(.DATA_W(4), .MSB_FIRST(1'b0)) dut_l (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready_l),
    .ser_en(ser_en),
    .dout(dout_l), .dout_valid(dout_valid_l),
    .dout_first(dout_first_l), .dout_last(dout_last_l)
  );

  piso_serializer #(.DATA_W(2), .MSB_FIRST(1'b1)) dut_2 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid2), .in_data(in_data2), .in_ready(in_ready2),
    .ser_en(ser_en2),
    .dout(dout2), .dout_valid(dout_valid2),
    .dout_first(dout_first2), .dout_last(dout_last2)
  );

  task automatic chk(input string tag, input logic obs, input logic exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // One cycle on the 4-bit instances: drive, settle, check dut outputs.
  task automatic step(input string tag, input logic r, input logic v,
                      input logic [3:0] d, input logic se,
                      input logic ev, input logic ed, input logic ef,
                      input logic el, input logic er);
    @(posedge clk);
    #1;
    rst = r; in_valid = v; in_data = d; ser_en = se;
    in_valid2 = 1'b0; in_data2 = 2'b00; ser_en2 = 1'b1;
    #1;
    $display("%-8s rst=%b in_valid=%b in_data=%h ser_en=%b | valid=%b dout=%b first=%b last=%b ready=%b",
             tag, r, v, d, se, dout_valid, dout, dout_first, dout_last, in_ready);
    chk({tag, ".valid"}, dout_valid, ev);
    chk({tag, ".dout"},  dout,       ed);
    chk({tag, ".first"}, dout_first, ef);
    chk({tag, ".last"},  dout_last,  el);
    chk({tag, ".ready"}, in_ready,   er);
  endtask

  // One cycle on the 2-bit instance; the 4-bit instances stay idle.
  task automatic step2(input string tag, input logic v, input logic [1:0] d,
                       input logic ev, input logic ed, input logic ef,
                       input logic el, input logic er);
    @(posedge clk);
    #1;
    rst = 1'b1; in_valid = 1'b0; in_data = 4'h0; ser_en = 1'b1;
    in_valid2 = v; in_data2 = d; ser_en2 = 1'b1;
    #1;
    $display("%-8s in_valid2=%b in_data2=%b | valid=%b dout=%b first=%b last=%b ready=%b",
             tag, v, d, dout_valid2, dout2, dout_first2, dout_last2, in_ready2);
    chk({tag, ".valid"}, dout_valid2, ev);
    chk({tag, ".dout"},  dout2,       ed);
    chk({tag, ".first"}, dout_first2, ef);
    chk({tag, ".last"},  dout_last2,  el);
    chk({tag, ".ready"}, in_ready2,   er);
  endtask

  task automatic chk_l(input string tag, input logic ev, input logic ed);
    chk({tag, ".lvalid"}, dout_valid_l, ev);
    chk({tag, ".ldout"},  dout_l,       ed);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset held with a word offered: nothing may load.
    rst = 1'b0; in_valid = 1'b1; in_data = 4'hF; ser_en = 1'b1;
    in_valid2 = 1'b0; in_data2 = 2'b00; ser_en2 = 1'b1;

    //    tag        rst v  data  se   val dout fst lst rdy
    step("rst0",    0, 1, 4'hF, 1,   0, 0, 0, 0, 1);
    step("rst1",    0, 1, 4'hF, 1,   0, 0, 0, 0, 1);
    step("rst2",    0, 1, 4'hF, 1,   0, 0, 0, 0, 1);
    step("rel",     1, 0, 4'h0, 1,   0, 0, 0, 0, 1);
    step("idle",    1, 0, 4'h0, 1,   0, 0, 0, 0, 1);

    // Single word 1011: MSB first 1,0,1,1; LSB first 1,1,0,1.
    step("t1_N",    1, 1, 4'hB, 1,   0, 0, 0, 0, 1);
    step("t1_b0",   1, 0, 4'h0, 1,   1, 1, 1, 0, 0);  chk_l("t1_b0", 1, 1);
    step("t1_b1",   1, 0, 4'h0, 1,   1, 0, 0, 0, 0);  chk_l("t1_b1", 1, 1);
    step("t1_b2",   1, 0, 4'h0, 1,   1, 1, 0, 0, 0);  chk_l("t1_b2", 1, 0);
    step("t1_b3",   1, 0, 4'h0, 1,   1, 1, 0, 1, 1);  chk_l("t1_b3", 1, 1);
    step("t1_end",  1, 0, 4'h0, 1,   0, 0, 0, 0, 1);  chk_l("t1_end", 0, 0);

    // Back-to-back A then 5: 1,0,1,0,0,1,0,1 with no gap.
    step("t2_N",    1, 1, 4'hA, 1,   0, 0, 0, 0, 1);
    step("t2_a0",   1, 1, 4'h5, 1,   1, 1, 1, 0, 0);
    step("t2_a1",   1, 1, 4'h5, 1,   1, 0, 0, 0, 0);
    step("t2_a2",   1, 1, 4'h5, 1,   1, 1, 0, 0, 0);
    step("t2_a3",   1, 1, 4'h5, 1,   1, 0, 0, 1, 1);
    step("t2_b0",   1, 0, 4'h0, 1,   1, 0, 1, 0, 0);
    step("t2_b1",   1, 0, 4'h0, 1,   1, 1, 0, 0, 0);
    step("t2_b2",   1, 0, 4'h0, 1,   1, 0, 0, 0, 0);
    step("t2_b3",   1, 0, 4'h0, 1,   1, 1, 0, 1, 1);
    step("t2_end",  1, 0, 4'h0, 1,   0, 0, 0, 0, 1);

    // Stall after the second bit of 1101, then a stall on the last bit.
    step("t3_N",    1, 1, 4'hD, 1,   0, 0, 0, 0, 1);
    step("t3_b0",   1, 0, 4'h0, 1,   1, 1, 1, 0, 0);
    step("t3_b1",   1, 0, 4'h0, 1,   1, 1, 0, 0, 0);
    step("t3_s0",   1, 0, 4'h0, 0,   1, 0, 0, 0, 0);
    step("t3_s1",   1, 0, 4'h0, 0,   1, 0, 0, 0, 0);
    step("t3_s2",   1, 0, 4'h0, 0,   1, 0, 0, 0, 0);
    step("t3_b2",   1, 0, 4'h0, 1,   1, 0, 0, 0, 0);
    step("t3_s3",   1, 1, 4'h6, 0,   1, 1, 0, 1, 0);
    step("t3_b3",   1, 0, 4'h0, 1,   1, 1, 0, 1, 1);
    step("t3_end",  1, 0, 4'h0, 1,   0, 0, 0, 0, 1);

    // Reset while cnt==2 abandons 0110; F then streams cleanly.
    step("t4_N",    1, 1, 4'h6, 1,   0, 0, 0, 0, 1);
    step("t4_b0",   1, 0, 4'h0, 1,   1, 0, 1, 0, 0);
    step("t4_b1",   1, 0, 4'h0, 1,   1, 1, 0, 0, 0);
    step("t4_rst",  0, 0, 4'h0, 1,   1, 1, 0, 0, 0);
    step("t4_N2",   1, 1, 4'hF, 1,   0, 0, 0, 0, 1);
    step("t4_f0",   1, 0, 4'h0, 1,   1, 1, 1, 0, 0);
    step("t4_f1",   1, 0, 4'h0, 1,   1, 1, 0, 0, 0);
    step("t4_f2",   1, 0, 4'h0, 1,   1, 1, 0, 0, 0);
    step("t4_f3",   1, 0, 4'h0, 1,   1, 1, 0, 1, 1);
    step("t4_end",  1, 0, 4'h0, 1,   0, 0, 0, 0, 1);

    // 3 offered while 9 is busy at cnt==1; taken on 9's last bit.
    step("t5_N",    1, 1, 4'h9, 1,   0, 0, 0, 0, 1);
    step("t5_a0",   1, 0, 4'h0, 1,   1, 1, 1, 0, 0);
    step("t5_a1",   1, 1, 4'h3, 1,   1, 0, 0, 0, 0);
    step("t5_a2",   1, 1, 4'h3, 1,   1, 0, 0, 0, 0);
    step("t5_a3",   1, 1, 4'h3, 1,   1, 1, 0, 1, 1);
    step("t5_b0",   1, 0, 4'h0, 1,   1, 0, 1, 0, 0);
    step("t5_b1",   1, 0, 4'h0, 1,   1, 0, 0, 0, 0);
    step("t5_b2",   1, 0, 4'h0, 1,   1, 1, 0, 0, 0);
    step("t5_b3",   1, 0, 4'h0, 1,   1, 1, 0, 1, 1);
    step("t5_end",  1, 0, 4'h0, 1,   0, 0, 0, 0, 1);

    // DATA_W=2: words 10 then 01 back-to-back; first/last once per word.
    //     tag        v  data   val dout fst lst rdy
    step2("w2_N",    1, 2'b10,  0, 0, 0, 0, 1);
    step2("w2_a0",   1, 2'b01,  1, 1, 1, 0, 0);
    step2("w2_a1",   1, 2'b01,  1, 0, 0, 1, 1);
    step2("w2_b0",   0, 2'b00,  1, 0, 1, 0, 0);
    step2("w2_b1",   0, 2'b00,  1, 1, 0, 1, 1);
    step2("w2_end",  0, 2'b00,  0, 0, 0, 0, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/piso_serializer.md
PISO_SERIALIZER -- requirements
Module: piso_serializer

Interface
REQ-001 Parameter DATA_W, default 4: parallel word width; legal range 2..32.
REQ-002 Parameter MSB_FIRST, default 1: 1 = bit DATA_W-1 is serialised first; 0 = bit 0 is serialised first.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  synchronous, active-low reset, sampled on the rising edge of clk.
REQ-005 in_valid  input  1  in_data holds a word offered for loading.
REQ-006 in_data  input  DATA_W  parallel word.
REQ-007 in_ready  output  1  block accepts the offered word this cycle.
REQ-008 ser_en  input  1  downstream consumes the current serial bit this cycle; 0 = stall.
REQ-009 dout  output  1  serial data bit.
REQ-010 dout_valid  output  1  dout carries a word bit.
REQ-011 dout_first  output  1  dout is the first bit of a word.
REQ-012 dout_last  output  1  dout is the last bit of a word.

Function
REQ-013 The block SHALL contain a DATA_W-bit shift register, a bit counter cnt of width clog2(DATA_W), and a two-state FSM: IDLE and SHIFT.
REQ-014 A word SHALL be accepted only in a cycle where in_valid=1 and in_ready=1.
REQ-015 in_ready SHALL equal (state==IDLE) OR (state==SHIFT AND cnt==DATA_W-1 AND ser_en==1); this is combinational from ser_en.
REQ-016 IDLE: on acceptance, load shreg<=in_data, set cnt<=0, and go to SHIFT; otherwise remain in IDLE.
REQ-017 SHIFT: dout_valid=1; dout=shreg[DATA_W-1] if MSB_FIRST, else shreg[0]; dout_first=(cnt==0); dout_last=(cnt==DATA_W-1).
REQ-018 SHIFT, ser_en=1, cnt<DATA_W-1: shift shreg one position toward the output end (zero fill) and increment cnt.
REQ-019 SHIFT, ser_en=1, cnt==DATA_W-1: on acceptance, reload shreg, set cnt<=0, and stay in SHIFT (no bubble); otherwise go to IDLE and set cnt<=0.
REQ-020 SHIFT, ser_en=0: shreg, cnt and the FSM state SHALL hold, and dout, dout_valid, dout_first and dout_last SHALL remain stable.
REQ-021 IDLE: dout=0, dout_valid=0, dout_first=0, dout_last=0.
REQ-022 Latency: a word accepted in cycle N SHALL present its first bit on dout in cycle N+1.
REQ-023 Throughput: with ser_en held at 1 and in_valid held at 1, one word SHALL be emitted every DATA_W cycles, with dout_valid continuously high.
REQ-024 While in_valid=1 and in_ready=0, the word SHALL NOT be consumed; the sender holds in_data stable until acceptance.
REQ-025 When DATA_W==2, dout_first and dout_last SHALL each be high for exactly one bit per word.

Reset
REQ-026 While rst=0 at a rising edge, the block SHALL set state=IDLE, shreg=0 and cnt=0; outputs then read dout=0, dout_valid=0, dout_first=0, dout_last=0, and in_ready=1 in the first cycle after release.
REQ-027 Reset asserted mid-word SHALL abandon the word with no further bits emitted; the first word accepted after reset release starts a fresh word with dout_first=1.
REQ-028 in_valid sampled during reset SHALL NOT load a word.

Verification
REQ-029 DATA_W=4, MSB_FIRST=1, ser_en=1, one word 4'b1011 -> dout = 1,0,1,1 in cycles N+1..N+4; first=1 in N+1; last=1 in N+4; dout_valid=0 in N+5.
REQ-030 DATA_W=4, MSB_FIRST=0, word 4'b1011 -> dout = 1,1,0,1; same first/last timing as REQ-029.
REQ-031 Back-to-back words 4'hA, 4'h5, in_valid held high, ser_en=1 -> 8 consecutive valid bits 1,0,1,0,0,1,0,1; in_ready pulses in the cycle each last bit is emitted.
REQ-032 Stall: ser_en=0 for 3 cycles after the second bit -> dout, first, last and dout_valid frozen; the word resumes with no bit lost or duplicated.
REQ-033 rst=0 while cnt==2 -> next cycle dout_valid=0, in_ready=1; a following word 4'hF emits all four bits with first/last asserted correctly.
REQ-034 in_valid=1 with new data 4'h3 while busy at cnt==1 -> word not taken until the last bit of the current word; 4'h3 follows with no bubble.
